instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
- Fetch stage between the program counter and the decoder.
- Holds the PC and drives it combinationally as the address of the asynchronous program ROM.
- Captures the returned 35-bit instruction into an output register and presents it to decode with a valid/ready handshake.
- Supports PC redirect (jump) with flush, downstream stall, and halt.

Parameters:
- ADDR_W, 8, PC / ROM address width.
- INSTR_W, 35, instruction width; matches the ROM data word.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- rom_addr  output  ADDR_W  ROM address; equals pc combinationally.
- rom_data  input  INSTR_W  ROM read data; valid in the same cycle as rom_addr (async ROM).
- instr  output  INSTR_W  registered instruction to decode.
- instr_pc  output  ADDR_W  address instr was fetched from.
- instr_valid  output  1  instr/instr_pc hold an unconsumed instruction.
- instr_ready  input  1  decoder accepts instr this cycle.
- jump_en  input  1  redirect request; single-cycle pulse.
- jump_addr  input  ADDR_W  redirect target.
- halt  input  1  stop fetching.
- halted  output  1  fetch stopped; high while in HALTED.

Behaviour:
- Clock, reset and update timing:
  - One clock. Reset is synchronous and active-high: sampled on the rising edge of clk.
  - Reset values: pc=RESET_PC, instr=0 (NOP), instr_pc=0, instr_valid=0, halted=0, state=RUN.
  - Reset dominates jump_en, halt and the handshake in the same cycle; an in-flight instruction is discarded.
- States:
  - RUN: fetching.
  - HALTED: fetch stopped.
- Transfer: a transfer occurs when instr_valid && instr_ready.
- Slot free: slot_free = !instr_valid || instr_ready.
- RUN, priority high to low:
  1. jump_en: pc<=jump_addr, instr_valid<=0 (flush), no capture this cycle. A transfer in the same cycle still completes (the decoder consumed it). The first instruction from jump_addr is valid two edges after jump_en is sampled.
  2. halt: state<=HALTED, halted<=1, no capture, pc unchanged. instr_valid is unchanged, except it clears if a transfer occurs this cycle.
  3. slot_free: instr<=rom_data, instr_pc<=pc, instr_valid<=1, pc<=pc+1.
  4. Otherwise (stall: instr_valid && !instr_ready): pc, instr, instr_pc held stable.
- Latency and throughput: one cycle from pc to instr_valid. With instr_ready held high, one instruction per cycle.
- PC arithmetic:
  - Modulo 2^ADDR_W; pc wraps from 2^ADDR_W-1 to 0 with no flag.
  - jump_addr is used as-is.
- HALTED:
  - No fetch and pc frozen.
  - A pending instr stays valid until accepted, then instr_valid<=0.
  - jump_en and halt are ignored.
  - Exit only via reset.
- Handshake rules:
  - While instr_valid && !instr_ready: instr and instr_pc must not change (except on jump flush or reset).
  - instr_valid never depends combinationally on instr_ready.
- ROM contents: rom_data for addresses beyond the ROM's populated range is 0 (NOP). It is fetched and passed on like any other instruction.

Test Plan:
- Reset, then instr_ready=1 for 11 cycles, with ROM words 0..9 = MOV-to-DOUT of values 1,3,...,19 → instr_pc 0,1,...,9,10 on consecutive cycles; immediate fields 1,3,...,19; the word at 10 is 35'b0; first instr_valid one cycle after reset deasserts.
- Stall: instr_ready=0 for 3 cycles while instr_pc=2 is valid → instr/instr_pc held at address 2's word and pc held at 3; on release, instr_pc 3 follows on the next cycle.
- Jump: pulse jump_en with jump_addr=7 while instr_pc=2 is valid and being accepted → next cycle instr_valid=0; cycle after, instr_pc=7 with immediate 15; then 8, 9.
- Wrap: jump_addr=255 (ADDR_W=8) → instr_pc 255 then 0 (immediate 1); no glitch.
- Halt: assert halt with instr_pc=4 valid and instr_ready=0 → halted=1, instr 4 held; raise instr_ready → accepted, instr_valid=0. A later jump_en is ignored; reset returns to pc=0, halted=0.
- Reset mid-stream and simultaneous events: reset with jump_en=1 and halt=1 → all outputs at reset values; fetch restarts at address 0.

Source files
------------

// File: rtl/instr_fetch.sv
// Fetch stage: drives the PC to an asynchronous ROM and registers the returned
// instruction toward decode over a valid/ready handshake, with jump, stall and halt.
module instr_fetch #(
  parameter int                 ADDR_W   = 8,
  parameter int                 INSTR_W  = 35,
  parameter logic [ADDR_W-1:0]  RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic               clk,
  input  logic               reset,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [INSTR_W-1:0] rom_data,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               jump_en,
  input  logic [ADDR_W-1:0]  jump_addr,
  input  logic               halt,
  output logic               halted
);

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;
  logic               instr_valid_q, instr_valid_d;
  logic               halted_q, halted_d;

  logic               transfer_s;
  logic               slot_free_s;

  assign transfer_s  = instr_valid_q && instr_ready;
  assign slot_free_s = !instr_valid_q || instr_ready;

  // Next-state logic: jump beats halt beats capture; otherwise the slot is stalled.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    halted_d      = halted_q;
    case (state_q)
      RUN: begin
        if (jump_en) begin
          pc_d          = jump_addr;
          instr_valid_d = 1'b0;
        end else if (halt) begin
          state_d  = HALTED;
          halted_d = 1'b1;
          if (transfer_s) begin
            instr_valid_d = 1'b0;
          end else begin
            instr_valid_d = instr_valid_q;
          end
        end else if (slot_free_s) begin
          instr_d       = rom_data;
          instr_pc_d    = pc_q;
          instr_valid_d = 1'b1;
          pc_d          = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        end else begin
          pc_d          = pc_q;
          instr_valid_d = instr_valid_q;
        end
      end
      HALTED: begin
        halted_d = 1'b1;
        if (transfer_s) begin
          instr_valid_d = 1'b0;
        end else begin
          instr_valid_d = instr_valid_q;
        end
      end
      default: begin
        state_d       = RUN;
        halted_d      = 1'b0;
        instr_valid_d = 1'b0;
      end
    endcase
  end

  // State registers with synchronous reset that overrides every other request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= RUN;
      pc_q          <= RESET_PC;
      instr_q       <= {INSTR_W{1'b0}};
      instr_pc_q    <= {ADDR_W{1'b0}};
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      halted_q      <= halted_d;
    end
  end

  assign rom_addr    = pc_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: the expected stream of accepted instructions
// is the sequential address walk from each reset/jump target, looked up in the ROM model.
module tb_instr_fetch;

  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 35;
  localparam logic [INSTR_W-1:0] MOV_DOUT = {4'hA, 31'h0};

  typedef struct {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] word;
  } exp_t;

  logic               clk = 1'b0;
  logic               reset;
  logic [ADDR_W-1:0]  rom_addr;
  logic [INSTR_W-1:0] rom_data;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  instr_pc;
  logic               instr_valid;
  logic               instr_ready;
  logic               jump_en;
  logic [ADDR_W-1:0]  jump_addr;
  logic               halt;
  logic               halted;

  logic [INSTR_W-1:0] rom [256];
  exp_t               exp_q[$];
  int                 checks = 0;
  int                 errors = 0;

  instr_fetch #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .RESET_PC(8'd0)) dut (
    .clk(clk), .reset(reset), .rom_addr(rom_addr), .rom_data(rom_data),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .jump_en(jump_en), .jump_addr(jump_addr),
    .halt(halt), .halted(halted)
  );

  always #5 clk = ~clk;

  assign rom_data = rom[rom_addr];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected accepted stream: consecutive addresses from start, wrapping mod 256.
  task automatic refill(input logic [ADDR_W-1:0] start);
    exp_t e;
    logic [ADDR_W-1:0] a;
    exp_q.delete();
    a = start;
    for (int i = 0; i < 2048; i++) begin
      e.pc   = a;
      e.word = rom[a];
      exp_q.push_back(e);
      a = a + 8'd1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; instr_ready = 1'b0; jump_en = 1'b0; halt = 1'b0;
    tick();
    reset = 1'b0;
    refill(8'd0);
  endtask

  task automatic chk_reset_vals();
    chk("rst_valid", {63'd0, instr_valid}, 64'd0);
    chk("rst_halted", {63'd0, halted}, 64'd0);
    chk("rst_instr", {29'd0, instr}, 64'd0);
    chk("rst_instr_pc", {56'd0, instr_pc}, 64'd0);
    chk("rst_rom_addr", {56'd0, rom_addr}, 64'd0);
  endtask

  // Monitor: every accepted instruction must be the next one the model predicts.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && instr_valid && instr_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_transfer: got instr_pc=%0d, required no transfer", instr_pc);
      end else begin
        e = exp_q.pop_front();
        chk("xfer_pc", {56'd0, instr_pc}, {56'd0, e.pc});
        chk("xfer_instr", {29'd0, instr}, {29'd0, e.word});
      end
    end
  end

  initial begin
    logic [ADDR_W-1:0] pend_addr;
    bit pend;
    for (int i = 0; i < 256; i++) rom[i] = {INSTR_W{1'b0}};
    for (int i = 0; i < 10; i++) rom[i] = MOV_DOUT | 35'(2 * i + 1);
    jump_addr = 8'd0;

    // Streaming from reset
    do_reset();
    chk_reset_vals();
    instr_ready = 1'b1;
    tick();
    for (int i = 0; i <= 10; i++) begin
      chk("stream_valid", {63'd0, instr_valid}, 64'd1);
      chk("stream_pc", {56'd0, instr_pc}, 64'(i));
      chk("stream_imm", {48'd0, instr[15:0]}, (i < 10) ? 64'(2 * i + 1) : 64'd0);
      tick();
    end

    // Stall at address 2
    do_reset();
    instr_ready = 1'b1;
    tick(); tick(); tick();
    instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_pc", {56'd0, instr_pc}, 64'd2);
      chk("stall_instr", {29'd0, instr}, {29'd0, rom[2]});
      chk("stall_rom_addr", {56'd0, rom_addr}, 64'd3);
    end
    instr_ready = 1'b1;
    tick();
    chk("unstall_pc", {56'd0, instr_pc}, 64'd3);

    // Jump to 7 while address 2 is being accepted
    do_reset();
    instr_ready = 1'b1;
    tick(); tick(); tick();
    jump_en = 1'b1; jump_addr = 8'd7;
    tick();
    jump_en = 1'b0;
    refill(8'd7);
    chk("jump_flush", {63'd0, instr_valid}, 64'd0);
    tick();
    chk("jump_pc7", {56'd0, instr_pc}, 64'd7);
    chk("jump_imm15", {48'd0, instr[15:0]}, 64'd15);
    tick();
    chk("jump_pc8", {56'd0, instr_pc}, 64'd8);
    tick();
    chk("jump_pc9", {56'd0, instr_pc}, 64'd9);

    // Wrap through 255
    jump_en = 1'b1; jump_addr = 8'd255;
    tick();
    jump_en = 1'b0;
    refill(8'd255);
    tick();
    chk("wrap_pc255", {56'd0, instr_pc}, 64'd255);
    chk("wrap_instr255", {29'd0, instr}, 64'd0);
    tick();
    chk("wrap_pc0", {56'd0, instr_pc}, 64'd0);
    chk("wrap_imm1", {48'd0, instr[15:0]}, 64'd1);
    chk("wrap_valid", {63'd0, instr_valid}, 64'd1);

    // Halt with address 4 pending and stalled
    do_reset();
    instr_ready = 1'b1;
    repeat (5) tick();
    instr_ready = 1'b0; halt = 1'b1;
    tick();
    halt = 1'b0;
    while (exp_q.size() > 1) void'(exp_q.pop_back());
    chk("halt_halted", {63'd0, halted}, 64'd1);
    chk("halt_valid", {63'd0, instr_valid}, 64'd1);
    chk("halt_pc", {56'd0, instr_pc}, 64'd4);
    tick();
    chk("halt_hold_instr", {29'd0, instr}, {29'd0, rom[4]});
    chk("halt_rom_addr", {56'd0, rom_addr}, 64'd5);
    instr_ready = 1'b1;
    tick();
    chk("halt_drain", {63'd0, instr_valid}, 64'd0);
    jump_en = 1'b1; jump_addr = 8'd7;
    tick();
    jump_en = 1'b0;
    tick(); tick();
    chk("halt_jump_ign_valid", {63'd0, instr_valid}, 64'd0);
    chk("halt_jump_ign_addr", {56'd0, rom_addr}, 64'd5);
    chk("halt_stays", {63'd0, halted}, 64'd1);

    // Reset together with jump and halt
    reset = 1'b1; jump_en = 1'b1; halt = 1'b1; jump_addr = 8'd9; instr_ready = 1'b1;
    tick();
    reset = 1'b0; jump_en = 1'b0; halt = 1'b0;
    refill(8'd0);
    chk_reset_vals();
    tick();
    chk("restart_pc0", {56'd0, instr_pc}, 64'd0);
    chk("restart_valid", {63'd0, instr_valid}, 64'd1);

    // Randomized traffic: ready, jumps and occasional resets
    pend = 1'b0;
    pend_addr = 8'd0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (pend) begin
        refill(pend_addr);
        pend = 1'b0;
      end
      instr_ready = ($urandom_range(3) != 0);
      reset = ($urandom_range(199) == 0);
      jump_en = 1'b0;
      if (reset) begin
        pend = 1'b1;
        pend_addr = 8'd0;
      end else if ($urandom_range(15) == 0) begin
        jump_en = 1'b1;
        jump_addr = 8'($urandom);
        pend = 1'b1;
        pend_addr = jump_addr;
      end
      tick();
    end
    reset = 1'b0; jump_en = 1'b0; instr_ready = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
